// File: rtl/dl_pkg.sv
// dl_pkg: word type, FSM states and address helper shared by the download writer
package dl_pkg;
    typedef struct packed {
        logic [23:1] a;
        logic [1:0]  ds;
        logic [15:0] d;
    } dl_word_t;
    typedef enum logic [1:0] {SYNC, IDLE, WAIT} dl_state_t;
    function automatic logic [23:1] word_addr(input logic [23:1] byte_word, input logic [22:0] base);
        return byte_word + base;
    endfunction
endpackage

// File: rtl/sdram_dl_writer_if.sv
// sdram_dl_writer_if: toggle req/ack write port towards the SDRAM controller
interface sdram_dl_writer_if;
    logic        port1_req;
    logic        port1_ack;
    logic        port1_we;
    logic [23:1] port1_a;
    logic [1:0]  port1_ds;
    logic [15:0] port1_d;
    modport master (output port1_req, port1_we, port1_a, port1_ds, port1_d, input port1_ack);
    modport slave  (input port1_req, port1_we, port1_a, port1_ds, port1_d, output port1_ack);
endinterface

// File: rtl/dl_fifo.sv
// dl_fifo: first-word-fall-through FIFO of dl_word_t; a push while full is dropped
module dl_fifo
    import dl_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  dl_word_t    din_i,
    input  logic        pop_i,
    output dl_word_t    dout_o,
    output logic [AW:0] count_o,
    output logic        full_o,
    output logic        empty_o
);
    dl_word_t      mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          wr, rd;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];
    assign wr      = push_i & ~full_o;
    assign rd      = pop_i & ~empty_o;
    always_ff @(posedge clk)
        if (wr) mem_q[wr_q] <= din_i;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(wr);
            rd_q  <= rd_q + AW'(rd);
            cnt_q <= cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
        end
endmodule

// File: rtl/sdram_dl_writer.sv
// sdram_dl_writer: packs ioctl download bytes into masked 16-bit words and
// issues them to the SDRAM controller over a toggle req/ack handshake.
module sdram_dl_writer
    import dl_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [22:0] BASE_WORD  = 23'd0,
    parameter logic [7:0]  DL_INDEX   = 8'd0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ioctl_downloading,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    sdram_dl_writer_if.master port1,
    output logic              dl_stall,
    output logic              overflow,
    output logic              rom_ready
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    dl_word_t      push_w, head, part_w;
    dl_state_t     state_q;
    logic [CW-1:0] count;
    logic [23:1]   wa, part_a_q, part_a_d;
    logic [7:0]    part_b_q, part_b_d;
    logic          push, pop, full, empty, acc, rise, fall, hit, done;
    logic          dl_q, pend_q, part_q, part_d;
    logic          unused_addr_msb;
    assign unused_addr_msb = ioctl_addr[24];
    assign acc    = ioctl_wr & ioctl_downloading & (ioctl_index == DL_INDEX);
    assign rise   = ioctl_downloading & ~dl_q;
    assign fall   = ~ioctl_downloading & dl_q;
    assign wa     = word_addr(ioctl_addr[23:1], BASE_WORD);
    assign hit    = part_q & (part_a_q == wa);
    assign part_w = '{a: part_a_q, ds: 2'b01, d: {8'h00, part_b_q}};
    // At most one push per cycle: an even byte evicts the old partial, an odd byte
    // completes or stands alone, and the download's end flushes what is left.
    always_comb begin
        push     = 1'b0;
        push_w   = part_w;
        part_d   = part_q;
        part_a_d = part_a_q;
        part_b_d = part_b_q;
        if (acc && ioctl_addr[0]) begin
            push   = 1'b1;
            push_w = '{a: wa, ds: hit ? 2'b11 : 2'b10, d: {ioctl_dout, hit ? part_b_q : 8'h00}};
            part_d = part_q & ~hit;
        end else if (acc) begin
            push     = part_q;
            part_d   = 1'b1;
            part_a_d = wa;
            part_b_d = ioctl_dout;
        end else if (fall) begin
            push   = part_q;
            part_d = 1'b0;
        end
    end
    dl_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .push_i  (push),
        .din_i   (push_w),
        .pop_i   (pop),
        .dout_o  (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );
    assign dl_stall = count >= CW'(FIFO_DEPTH - 1);
    assign pop      = (state_q == IDLE) & ~empty;
    // pend_q remembers that a download happened, so rom_ready never rises out of reset alone
    assign done     = pend_q & ~ioctl_downloading & ~part_q & empty & (state_q == IDLE);
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            dl_q      <= 1'b0;
            pend_q    <= 1'b0;
            part_q    <= 1'b0;
            part_a_q  <= '0;
            part_b_q  <= '0;
            overflow  <= 1'b0;
            rom_ready <= 1'b0;
        end else begin
            dl_q      <= ioctl_downloading;
            pend_q    <= ioctl_downloading | (pend_q & ~done);
            part_q    <= part_d;
            part_a_q  <= part_a_d;
            part_b_q  <= part_b_d;
            overflow  <= (overflow & ~rise) | (push & full);
            rom_ready <= ~rise & (rom_ready | done);
        end
    assign port1.port1_we = 1'b1;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q         <= SYNC;
            port1.port1_req <= 1'b0;
            port1.port1_a   <= '0;
            port1.port1_ds  <= '0;
            port1.port1_d   <= '0;
        end else begin
            case (state_q)
                SYNC: begin
                    port1.port1_req <= port1.port1_ack;
                    state_q         <= IDLE;
                end
                IDLE: if (!empty) begin
                    port1.port1_a   <= head.a;
                    port1.port1_ds  <= head.ds;
                    port1.port1_d   <= head.d;
                    port1.port1_req <= ~port1.port1_req;
                    state_q         <= WAIT;
                end
                default: if (port1.port1_ack == port1.port1_req) state_q <= IDLE;
            endcase
        end
endmodule
